// File: rtl/ahb_lite_master_if.sv
// AHB-Lite signal bundle between the initiator and the bridge's AHB slave port.
interface ahb_lite_master_if;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic        Hwrite;
    logic [31:0] Hwdata;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;

    modport master (
        output Htrans, Haddr, Hwrite, Hwdata,
        input  Hreadyout, Hresp, Hrdata
    );

    modport slave (
        input  Htrans, Haddr, Hwrite, Hwdata,
        output Hreadyout, Hresp, Hrdata
    );
endinterface

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns one command into a single or INCR word burst.
// Optional macro AHB_MST_ERR_ABORT_EN: an ERROR response cancels the rest of the burst.
module ahb_lite_master #(
    parameter int MAX_BEATS = 16,
    parameter int LEN_W     = 5
) (
    input  logic             Hclk,
    input  logic             Hresetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [31:0]      wdata,
    output logic             wdata_ack,
    output logic [31:0]      rdata,
    output logic             rdata_valid,
    output logic             done,
    output logic             err,
    ahb_lite_master_if.master ahb
);
    localparam logic [1:0]       HT_IDLE   = 2'b00;
    localparam logic [1:0]       HT_NONSEQ = 2'b10;
    localparam logic [1:0]       HT_SEQ    = 2'b11;
    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_BEATS);
    localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_LAST, S_ERR} state_t;

    state_t           state_q, state_d;
    logic [31:0]      cmd_addr_q, cmd_addr_d;
    logic             cmd_write_q, cmd_write_d;
    logic [LEN_W-1:0] beats_q, beats_d;
    logic [1:0]       htrans_q, htrans_d;
    logic [31:0]      haddr_q, haddr_d;
    logic             hwrite_q, hwrite_d;
    logic [31:0]      hwdata_q, hwdata_d;
    logic             dphase_q, dphase_d;
    logic             dwrite_q, dwrite_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rdata_valid_q, rdata_valid_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             accept, addr_done, last_beat, dphase_end, err_first, abort;
    logic [31:0]      next_addr;
    logic [LEN_W-1:0] len_eff;

    assign accept     = cmd_valid && (state_q == S_IDLE);
    assign addr_done  = (state_q == S_BURST) && ahb.Hreadyout;
    assign last_beat  = (beats_q == ONE);
    assign dphase_end = dphase_q && ahb.Hreadyout;
    // First cycle of the two-cycle ERROR response.
    assign err_first  = dphase_q && !ahb.Hreadyout && (ahb.Hresp != 2'b00);
    assign next_addr  = haddr_q + 32'd4;
    assign len_eff    = (cmd_len == '0)     ? ONE :
                        (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;

`ifdef AHB_MST_ERR_ABORT_EN
    assign abort = err_first;
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q       <= S_IDLE;
            cmd_addr_q    <= '0;
            cmd_write_q   <= 1'b0;
            beats_q       <= '0;
            htrans_q      <= HT_IDLE;
            haddr_q       <= '0;
            hwrite_q      <= 1'b0;
            hwdata_q      <= '0;
            dphase_q      <= 1'b0;
            dwrite_q      <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_write_q   <= cmd_write_d;
            beats_q       <= beats_d;
            htrans_q      <= htrans_d;
            haddr_q       <= haddr_d;
            hwrite_q      <= hwrite_d;
            hwdata_q      <= hwdata_d;
            dphase_q      <= dphase_d;
            dwrite_q      <= dwrite_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_ADDR;
            S_ADDR:  state_d = S_BURST;
            S_BURST: begin
                if (abort)                       state_d = S_ERR;
                else if (addr_done && last_beat) state_d = S_LAST;
            end
            S_LAST: begin
                if (abort)           state_d = S_ERR;
                else if (dphase_end) state_d = S_IDLE;
            end
            S_ERR:   if (dphase_end) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_addr_d    = cmd_addr_q;
        cmd_write_d   = cmd_write_q;
        beats_d       = beats_q;
        htrans_d      = htrans_q;
        haddr_d       = haddr_q;
        hwrite_d      = hwrite_q;
        hwdata_d      = hwdata_q;
        dphase_d      = dphase_q;
        dwrite_d      = dwrite_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        done_d        = 1'b0;
        err_d         = err_q;

        if (accept) begin
            cmd_addr_d  = cmd_addr & ~32'h3;
            cmd_write_d = cmd_write;
            beats_d     = len_eff;
            err_d       = 1'b0;
        end
        if (state_q == S_ADDR) begin
            htrans_d = HT_NONSEQ;
            haddr_d  = cmd_addr_q;
            hwrite_d = cmd_write_q;
        end
        if (addr_done) begin
            beats_d = beats_q - ONE;
            if (hwrite_q) hwdata_d = wdata;
            if (last_beat) begin
                htrans_d = HT_IDLE;
            end else begin
                haddr_d  = next_addr;
                // INCR bursts must not cross a 1KB boundary, so restart there.
                htrans_d = (next_addr[9:0] == 10'd0) ? HT_NONSEQ : HT_SEQ;
            end
        end
        if (abort) htrans_d = HT_IDLE;
        if (ahb.Hreadyout) begin
            dphase_d = (htrans_q != HT_IDLE);
            dwrite_d = hwrite_q;
        end
        if (dphase_end && !dwrite_q && (state_q != S_ERR)) begin
            rdata_d       = ahb.Hrdata;
            rdata_valid_d = 1'b1;
        end
        if (dphase_end && ((state_q == S_LAST) || (state_q == S_ERR))) done_d = 1'b1;
        if (err_first) err_d = 1'b1;
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign wdata_ack   = addr_done && hwrite_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign done        = done_q;
    assign err         = err_q;
    assign ahb.Htrans  = htrans_q;
    assign ahb.Haddr   = haddr_q;
    assign ahb.Hwrite  = hwrite_q;
    assign ahb.Hwdata  = hwdata_q;
endmodule

// File: tb/tb_ahb_lite_master.sv
// Scoreboard bench for ahb_lite_master: directed commands, a wait/error-capable slave, and a monitor.
module tb_ahb_lite_master;
    logic        clk;
    logic        Hresetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [4:0]  cmd_len;
    logic [31:0] wdata;
    logic        wdata_ack;
    logic [31:0] rdata;
    logic        rdata_valid, done, err;

    ahb_lite_master_if bus();

    ahb_lite_master #(.MAX_BEATS(16), .LEN_W(5)) dut (
        .Hclk(clk), .Hresetn(Hresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata(wdata), .wdata_ack(wdata_ack),
        .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .err(err),
        .ahb(bus.master)
    );

    typedef struct { logic [1:0] ht; logic [31:0] a; logic w; } exp_addr_t;
    typedef struct { int n_ack; int n_rv; logic e; } exp_done_t;

    exp_addr_t   addr_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] rd_q[$];
    exp_done_t   done_q[$];
    logic [31:0] wq[$];

    int vectors = 0;
    int miscompares = 0;
    int stall_beat = 0, stall_n = 0, err_beat = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got unexpected or missing event, expected none", name);
    endtask

    task automatic push_a(input logic [1:0] ht, input logic [31:0] a, input logic w);
        exp_addr_t e;
        e.ht = ht; e.a = a; e.w = w;
        addr_q.push_back(e);
    endtask

    task automatic push_done(input int na, input int nr, input logic e);
        exp_done_t d;
        d.n_ack = na; d.n_rv = nr; d.e = e;
        done_q.push_back(d);
    endtask

    task automatic plan(input int sb, input int sn, input int eb);
        stall_beat = sb; stall_n = sn; err_beat = eb;
    endtask

    // Called at posedge+1; returns cycles from accept edge to visible done.
    task automatic issue(input logic w, input logic [31:0] a, input logic [4:0] l,
                         input bit wait_done, output int lat);
        int n;
        cmd_write = w; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (!cmd_ready) miss("cmd_ready_timeout");
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0;
        if (wait_done) begin
            while (!done && lat < 400) begin @(posedge clk); #1; lat++; end
            if (!done) miss("done_timeout");
        end
    endtask

    // Slave: wait states / two-cycle ERROR per beat plan, plus the wdata source.
    initial begin : slave
        int beat, wait_cnt, err_stage;
        logic dp_act, ack_pend;
        logic [31:0] dp_addr;
        bus.Hreadyout = 1'b1; bus.Hresp = 2'b00; bus.Hrdata = '0; wdata = '0;
        beat = 0; wait_cnt = 0; err_stage = 0; dp_act = 1'b0; ack_pend = 1'b0; dp_addr = '0;
        forever begin
            @(negedge clk);
            if (!Hresetn) begin
                dp_act = 1'b0; ack_pend = 1'b0; wait_cnt = 0; err_stage = 0;
                bus.Hreadyout = 1'b1; bus.Hresp = 2'b00;
            end else begin
                if (ack_pend) begin
                    wdata = (wq.size() != 0) ? wq.pop_front() : 32'h0;
                    ack_pend = 1'b0;
                end
                if (cmd_valid && cmd_ready) begin
                    beat = 0;
                    if (wq.size() != 0) wdata = wq.pop_front();
                end
                if (dp_act && wait_cnt > 0) begin
                    bus.Hreadyout = 1'b0; bus.Hresp = 2'b00; wait_cnt--;
                end else if (dp_act && err_stage == 1) begin
                    bus.Hreadyout = 1'b0; bus.Hresp = 2'b01; err_stage = 2;
                end else if (dp_act) begin
                    bus.Hreadyout = 1'b1;
                    bus.Hresp = (err_stage == 2) ? 2'b01 : 2'b00;
                    err_stage = 0;
                    bus.Hrdata = dp_addr ^ 32'h5A5A_5A5A;
                end else begin
                    bus.Hreadyout = 1'b1; bus.Hresp = 2'b00;
                end
                #1;
                if (wdata_ack) ack_pend = 1'b1;
                if (bus.Hreadyout) begin
                    if (bus.Htrans != 2'b00) begin
                        beat++;
                        dp_act = 1'b1; dp_addr = bus.Haddr;
                        wait_cnt = (beat == stall_beat) ? stall_n : 0;
                        err_stage = (beat == err_beat) ? 1 : 0;
                    end else begin
                        dp_act = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a transfer, data or pulse.
    initial begin : monitor
        logic dp_valid, dp_write;
        int n_ack, n_rv;
        exp_addr_t ea;
        exp_done_t ed;
        dp_valid = 1'b0; dp_write = 1'b0; n_ack = 0; n_rv = 0;
        forever begin
            @(negedge clk); #2;
            if (!Hresetn) begin
                dp_valid = 1'b0; n_ack = 0; n_rv = 0;
            end else begin
                if (dp_valid && bus.Hreadyout && dp_write) begin
                    if (wd_q.size() == 0) miss("hwdata_unexpected");
                    else chk("hwdata", {32'h0, bus.Hwdata}, {32'h0, wd_q.pop_front()});
                end
                if (bus.Htrans != 2'b00 && bus.Hreadyout) begin
                    if (addr_q.size() == 0) miss("addr_phase_unexpected");
                    else begin
                        ea = addr_q.pop_front();
                        chk("addr_phase", {29'h0, bus.Htrans, bus.Hwrite, bus.Haddr},
                            {29'h0, ea.ht, ea.w, ea.a});
                    end
                end
                if (wdata_ack) n_ack++;
                if (rdata_valid) begin
                    n_rv++;
                    if (rd_q.size() == 0) miss("rdata_unexpected");
                    else chk("rdata", {32'h0, rdata}, {32'h0, rd_q.pop_front()});
                end
                if (done) begin
                    if (done_q.size() == 0) miss("done_unexpected");
                    else begin
                        ed = done_q.pop_front();
                        chk("done_acks_rvalids_err", {16'h0, 16'(n_ack), 16'(n_rv), 15'h0, err},
                            {16'h0, 16'(ed.n_ack), 16'(ed.n_rv), 15'h0, ed.e});
                    end
                    n_ack = 0; n_rv = 0;
                end
                if (bus.Hreadyout) begin
                    dp_valid = (bus.Htrans != 2'b00);
                    dp_write = bus.Hwrite;
                end
            end
        end
    end

    initial begin : stimulus
        int lat;
        Hresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        repeat (3) @(posedge clk);
        #1 Hresetn = 1'b1;
        chk("rst_htrans", {62'h0, bus.Htrans}, 64'h0);
        chk("rst_haddr_hwdata", {bus.Haddr, bus.Hwdata}, 64'h0);
        chk("rst_ready_done_err_rv_wr", {59'h0, cmd_ready, done, err, rdata_valid, bus.Hwrite}, 64'h10);
        chk("rst_rdata", {32'h0, rdata}, 64'h0);

        // Single write, zero waits: done three cycles after accept.
        plan(0, 0, 0); wq.delete(); wq.push_back(32'h8400_0000);
        push_a(2'b10, 32'h8000_1100, 1'b1); wd_q.push_back(32'h8400_0000); push_done(1, 0, 1'b0);
        issue(1'b1, 32'h8000_1100, 5'd1, 1'b1, lat);
        chk("single_wr_latency", 64'(lat), 64'd3);

        // 4-beat read, two wait states on beat 2.
        plan(2, 2, 0); wq.delete();
        push_a(2'b10, 32'h8000_0000, 1'b0); push_a(2'b11, 32'h8000_0004, 1'b0);
        push_a(2'b11, 32'h8000_0008, 1'b0); push_a(2'b11, 32'h8000_000C, 1'b0);
        rd_q.push_back(32'hDA5A_5A5A); rd_q.push_back(32'hDA5A_5A5E);
        rd_q.push_back(32'hDA5A_5A52); rd_q.push_back(32'hDA5A_5A56);
        push_done(0, 4, 1'b0);
        issue(1'b0, 32'h8000_0000, 5'd4, 1'b1, lat);

        // Write burst crossing a 1KB boundary (byte offset bits ignored).
        plan(0, 0, 0); wq.delete();
        for (int i = 0; i < 4; i++) begin
            wq.push_back(32'h4444_0000 + 32'(i)); wd_q.push_back(32'h4444_0000 + 32'(i));
        end
        push_a(2'b10, 32'h8000_03F8, 1'b1); push_a(2'b11, 32'h8000_03FC, 1'b1);
        push_a(2'b10, 32'h8000_0400, 1'b1); push_a(2'b11, 32'h8000_0404, 1'b1);
        push_done(4, 0, 1'b0);
        issue(1'b1, 32'h8000_03FB, 5'd4, 1'b1, lat);

        // ERROR on beat 2 of a 4-beat write.
        plan(0, 0, 2); wq.delete();
        for (int i = 0; i < 4; i++) wq.push_back(32'h5555_0000 + 32'(i));
        push_a(2'b10, 32'h8000_0100, 1'b1); push_a(2'b11, 32'h8000_0104, 1'b1);
        wd_q.push_back(32'h5555_0000); wd_q.push_back(32'h5555_0001);
`ifdef AHB_MST_ERR_ABORT_EN
        push_done(2, 0, 1'b1);
`else
        push_a(2'b11, 32'h8000_0108, 1'b1); push_a(2'b11, 32'h8000_010C, 1'b1);
        wd_q.push_back(32'h5555_0002); wd_q.push_back(32'h5555_0003);
        push_done(4, 0, 1'b1);
`endif
        issue(1'b1, 32'h8000_0100, 5'd4, 1'b1, lat);

        // Asynchronous reset in the middle of a write burst: no done, outputs cleared at once.
        plan(0, 0, 0); wq.delete();
        for (int i = 0; i < 4; i++) wq.push_back(32'h6666_0000 + 32'(i));
        push_a(2'b10, 32'h8000_0200, 1'b1);
        issue(1'b1, 32'h8000_0200, 5'd4, 1'b0, lat);
        @(posedge clk); #1;
        @(posedge clk); #3;
        Hresetn = 1'b0;
        #1;
        chk("midrst_htrans", {62'h0, bus.Htrans}, 64'h0);
        chk("midrst_haddr_hwdata", {bus.Haddr, bus.Hwdata}, 64'h0);
        chk("midrst_ready_done_err_rv_wr", {59'h0, cmd_ready, done, err, rdata_valid, bus.Hwrite}, 64'h10);
        chk("midrst_rdata", {32'h0, rdata}, 64'h0);
        @(posedge clk); #1;
        Hresetn = 1'b1;

        // Normal single read after the reset.
        wq.delete();
        push_a(2'b10, 32'h8000_0010, 1'b0); rd_q.push_back(32'hDA5A_5A4A); push_done(0, 1, 1'b0);
        issue(1'b0, 32'h8000_0010, 5'd1, 1'b1, lat);

        // cmd_len = 0 runs one beat.
        wq.delete(); wq.push_back(32'h0BAD_F00D);
        push_a(2'b10, 32'h8000_0020, 1'b1); wd_q.push_back(32'h0BAD_F00D); push_done(1, 0, 1'b0);
        issue(1'b1, 32'h8000_0020, 5'd0, 1'b1, lat);

        // cmd_len = 31 is clamped to 16 beats.
        wq.delete();
        for (int i = 0; i < 16; i++) begin
            wq.push_back(32'hC0DE_0000 + 32'(i)); wd_q.push_back(32'hC0DE_0000 + 32'(i));
            push_a((i == 0) ? 2'b10 : 2'b11, 32'h8000_0040 + 32'(4 * i), 1'b1);
        end
        push_done(16, 0, 1'b0);
        issue(1'b1, 32'h8000_0040, 5'd31, 1'b1, lat);

        repeat (5) @(posedge clk);
        #1;
        chk("left_addr_phases", 64'(addr_q.size()), 64'd0);
        chk("left_hwdata", 64'(wd_q.size()), 64'd0);
        chk("left_rdata", 64'(rd_q.size()), 64'd0);
        chk("left_done", 64'(done_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end
endmodule
